opb_register_bank_simulink2ppc: RTL

//  Multi-channel successor to the single simulink2ppc OPB register. Captures C_NUM_CH user words
//  on per-channel strobes and freezes all of them atomically into a shadow bank. The PPC reads
//  the frozen bank over OPB. Per-channel sticky update flags show what changed since the last clear.

---
 rtl/opb_register_bank_simulink2ppc.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel OPB register bank: live per-channel capture, atomic snapshot into a shadow bank read by the PPC.
// Optional cycle timestamp on each snapshot when OPB_REGBANK_TIMESTAMP_EN is defined.
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_CH      = 4,
  parameter int          C_USER_DWIDTH = 32
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]           OPB_ABus,
  input  logic [0:3]                        OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]           OPB_DBus,
  input  logic                              OPB_RNW,
  input  logic                              OPB_select,
  input  logic                              OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]           Sl_DBus,
  output logic                              Sl_xferAck,
  output logic                              Sl_errAck,
  output logic                              Sl_retry,
  output logic                              Sl_toutSup,
  input  logic [C_NUM_CH*C_USER_DWIDTH-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]               user_valid,
  input  logic                              user_snap,
  output logic                              snap_done,
  output logic [1:0]                        dbg_state
);

  // Bus handshake: Sl_xferAck is high for exactly one cycle per OPB_select
  // assertion that hits the window; Sl_DBus carries read data only in that
  // cycle; the slave then waits for OPB_select to drop before re-arming.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [C_OPB_AWIDTH-1:0] SPAN =
    C_HIGHADDR[C_OPB_AWIDTH-1:0] - C_BASEADDR[C_OPB_AWIDTH-1:0];

  state_t                    state;
  logic [C_OPB_AWIDTH-1:0]   offset;
  logic [C_OPB_AWIDTH-1:0]   word;
  logic [C_OPB_AWIDTH-1:0]   word_q;
  logic                      rnw_q;
  logic                      hit;
  logic [C_OPB_DWIDTH-1:0]   rdata;

  logic [C_USER_DWIDTH-1:0]  live   [C_NUM_CH];
  logic [C_USER_DWIDTH-1:0]  shadow [C_NUM_CH];
  logic [C_NUM_CH-1:0]       flags;
  logic [31:0]               tstamp;

  logic                      ctrl_wr;
  logic                      snap_req;
  logic                      flag_clr;
  logic                      unused_bits;

  // Addresses below the base wrap to a large offset and so miss the window.
  assign offset = OPB_ABus - C_BASEADDR[C_OPB_AWIDTH-1:0];
  assign word   = offset >> 2;
  assign hit    = OPB_select && (offset <= SPAN);

  assign ctrl_wr  = (state == ST_ACK) && !rnw_q && (word_q == '0) && OPB_BE[3];
  assign snap_req = user_snap || (ctrl_wr && OPB_DBus[C_OPB_DWIDTH-1]);
  assign flag_clr = ctrl_wr && OPB_DBus[C_OPB_DWIDTH-2];

  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign dbg_state   = state;
  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3]};

  always_comb begin
    rdata = '0;
    if (word == '0)
      rdata = C_OPB_DWIDTH'({8'(C_NUM_CH), 8'(C_USER_DWIDTH), 16'h0000});
    else if (word == C_OPB_AWIDTH'(1))
      rdata = C_OPB_DWIDTH'(flags);
    else if (word == C_OPB_AWIDTH'(2))
      rdata = C_OPB_DWIDTH'(tstamp);
    for (int i = 0; i < C_NUM_CH; i++) begin
      if (word == C_OPB_AWIDTH'(i + 4))
        rdata = C_OPB_DWIDTH'(shadow[i]);
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state      <= ST_IDLE;
      Sl_xferAck <= 1'b0;
      Sl_DBus    <= '0;
      word_q     <= '0;
      rnw_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state      <= ST_ACK;
            Sl_xferAck <= 1'b1;
            Sl_DBus    <= OPB_RNW ? rdata : '0;
            word_q     <= word;
            rnw_q      <= OPB_RNW;
          end
        end
        ST_ACK: begin
          state      <= ST_HOLD;
          Sl_xferAck <= 1'b0;
          Sl_DBus    <= '0;
        end
        ST_HOLD: begin
          if (!OPB_select) state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          Sl_xferAck <= 1'b0;
          Sl_DBus    <= '0;
        end
      endcase
    end
  end

  // Shadow copies the pre-edge live value, so a same-cycle valid lands in
  // live only and is picked up by the next snapshot.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      flags     <= '0;
      snap_done <= 1'b0;
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (user_valid[i]) live[i] <= user_data_in[i*C_USER_DWIDTH +: C_USER_DWIDTH];
        if (snap_req) shadow[i] <= live[i];
      end
      if (flag_clr) flags <= user_valid;
      else          flags <= flags | user_valid;
      snap_done <= snap_req;
    end
  end

`ifdef OPB_REGBANK_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (snap_req) tstamp <= ts_cnt;
    end
  end
`else
  assign tstamp = '0;
`endif

endmodule
